dff_ram_1r1w: RTL and testbench
===============================

# dff_ram_1r1w

Parametrised flip-flop RAM with one write port and one read port, the successor to the fixed 4x72 single-port DFF RAM. It adds configurable width, depth and lane size, per-lane write masking, and same-cycle independent read and write. Read-during-write to the same address forwards the new data, and a registered `rvalid` qualifies each read. It serves small register-file and buffer storage in the core where SRAM macros are too coarse.

## Interface
- `WIDTH`, 72: data width in bits; must be a multiple of `LANE_W`.
- `DEPTH`, 4: number of words; any value ≥ 2, not necessarily a power of two.
- `LANE_W`, 8: bits per write-mask lane; `LANES = WIDTH/LANE_W`; `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `we_n`  in  1  write enable, active-low.
- `waddr`  in  AW  write address.
- `wdata`  in  WIDTH  write data.
- `wmask`  in  LANES  per-lane write mask; 1 = write that lane.
- `re_n`  in  1  read enable, active-low.
- `raddr`  in  AW  read address.
- `rdata`  out  WIDTH  registered read data.
- `rvalid`  out  1  `rdata` updated this cycle.
- `perr`  out  1  parity error on the current read; see Configuration.

## Operation
- Write (`we_n`=0):
  - Lane i of word `waddr` takes `wdata[i*LANE_W +: LANE_W]` where `wmask[i]`=1.
  - Unmasked lanes keep their value.
- Read (`re_n`=0): `rdata` ← word `raddr`; `rvalid` ← 1.
- Idle read (`re_n`=1): `rdata` holds its last value; `rvalid` ← 0.
- Read and write in the same cycle, different addresses: both complete independently.
- Read and write in the same cycle, same address (write-first):
  - Masked lanes return the new `wdata`.
  - Unmasked lanes return the stored value.
- Out-of-range address (≥ `DEPTH`):
  - Write is dropped and storage is unchanged.
  - Read returns all zeros with `rvalid`=1 and `perr`=0.
- `wmask` = 0 with `we_n`=0 is a legal no-op write.
- X on `waddr`/`raddr` while the corresponding enable is inactive has no effect.

## Timing
- Read latency is 1 cycle: `raddr` sampled at edge N appears on `rdata` and `rvalid` after edge N.
- Write is visible to a separate read issued the following cycle, and to a same-cycle read through forwarding.
- Back-to-back reads and writes at full rate; no stall or backpressure.
- Reset, while `rst`=1 at an edge:
  - All storage, `rdata`, `rvalid` and `perr` go to 0.
  - Any concurrent read or write is ignored; reset dominates.
- Reset deasserted at edge N: the first access is accepted at edge N+1.
- Reset mid-stream: a read sampled in the reset cycle produces no `rvalid`.

## Configuration
- Macro `DFF_RAM_PARITY_EN`.
- Defined:
  - One even-parity bit is stored per lane, computed from the written lane data. Storage is `DEPTH x (WIDTH+LANES)`.
  - On every read, parity is recomputed over the read lanes, including forwarded ones, and compared with the stored or forwarded parity bits.
  - `perr` is registered together with `rdata`; it is 1 if any lane mismatches and valid only when `rvalid`=1. Otherwise it is 0.
  - Masked writes update only the parity bits of written lanes.
- Not defined:
  - No parity storage or logic.
  - `perr` is tied to 0 and the port list is unchanged.

## Structure
- Package `dff_ram_pkg`:
  - `lanes_f(WIDTH, LANE_W)` and `aw_f(DEPTH)` functions.
  - Elaboration-time check that `WIDTH % LANE_W == 0`.
  - Lane-slice typedef.
- Sub-module `dff_ram_lane`: one lane column.
  - Handles masked write and write-first forward mux.
  - Handles the parity bit under the macro.
- The top generates `LANES` instances and owns `rvalid`, the address-range checks and the reset.

## Test plan
- Reset then sequential access: write `72'hFF_0123456789ABCDEF` to addr 2 with `wmask`=9'h1FF; read addr 2 next cycle → `rdata` equals that value, `rvalid`=1 for one cycle.
- Masked write: addr 1 holds all-ones; write `wdata`=0 with `wmask`=9'h001 → read returns `72'hFF_FFFFFFFFFFFFFF00`.
- Same-address read/write: addr 0 = 0; in the same cycle, write `wdata`=all-`A5` with `wmask`=9'h0F0 and read addr 0 → `rdata` = `72'h00_A5A5A5A5_00000000`.
- Hold and out-of-range (`DEPTH`=5): read addr 3, then `re_n`=1 for 3 cycles → `rdata` holds, `rvalid`=0; a write to addr 6 is dropped, and a read of addr 6 → 0 with `rvalid`=1.
- Reset mid-stream: write addr 3 = `72'h1`, assert `rst` in the same cycle as a read of addr 3 → no `rvalid`; after reset, a read of addr 3 returns 0.
- `DFF_RAM_PARITY_EN`: write addr 1 = `72'h3`, force-flip stored bit 0 → read gives `perr`=1 with `rvalid`=1; a clean read of addr 0 → `perr`=0.

Source files
------------

// File: rtl/dff_ram_pkg.sv
// Shared helpers and types for the parametrised 1R1W flip-flop RAM.
// Optional parity (DFF_RAM_PARITY_EN) is selected per build in the lane and top files.
package dff_ram_pkg;

  localparam int unsigned DEF_LANE_W = 8;

  // Default lane slice; the top overrides it with its own LANE_W-wide type.
  typedef logic [DEF_LANE_W-1:0] lane_t;

  function automatic int unsigned lanes_f(input int unsigned width, input int unsigned lane_w);
    return width / lane_w;
  endfunction

  function automatic int unsigned aw_f(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit lane_fit_f(input int unsigned width, input int unsigned lane_w);
    return (lane_w != 0) && ((width % lane_w) == 0);
  endfunction

endpackage

// File: rtl/dff_ram_lane.sv
// One lane column of the 1R1W DFF RAM: masked write, write-first forwarding,
// and a per-word even-parity bit when DFF_RAM_PARITY_EN is defined.
module dff_ram_lane
  import dff_ram_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AW          = 2,
  parameter type         lane_data_t = lane_t
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  lane_data_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output lane_data_t    rdata_o,
  output logic          perr_o
);

  lane_data_t mem_q [DEPTH];
  logic       fwd;

  // we_i is only raised for in-range addresses with this lane's mask bit set.
  assign fwd     = we_i && (waddr_i == raddr_i);
  assign rdata_o = fwd ? wdata_i : mem_q[raddr_i];

  // NOTE: storage is cleared on reset on purpose; every word must read 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef DFF_RAM_PARITY_EN
  logic par_q [DEPTH];
  logic rpar;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
    end else if (we_i) begin
      par_q[waddr_i] <= ^wdata_i;
    end
  end

  assign rpar   = fwd ? ^wdata_i : par_q[raddr_i];
  assign perr_o = (^rdata_o) ^ rpar;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/dff_ram_1r1w.sv
// Parametrised flip-flop RAM, one write and one read port, per-lane write mask,
// write-first same-address forwarding. Parity enabled by DFF_RAM_PARITY_EN.
module dff_ram_1r1w
  import dff_ram_pkg::*;
#(
  parameter  int unsigned WIDTH  = 72,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned LANE_W = 8,
  localparam int unsigned LANES  = lanes_f(WIDTH, LANE_W),
  localparam int unsigned AW     = aw_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_n,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [LANES-1:0] wmask,
  input  logic             re_n,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             perr
);

  if (!lane_fit_f(WIDTH, LANE_W)) begin : g_bad_cfg
    $error("dff_ram_1r1w: WIDTH must be a non-zero multiple of LANE_W");
  end

  typedef logic [LANE_W-1:0] lane_slice_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] rd_word;
  logic [LANES-1:0] lane_perr;

  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             perr_q, perr_d;

  // Out-of-range writes are dropped here, so lanes never see them.
  assign wr_ok = !we_n && ({1'b0, waddr} < DEPTH_L);
  assign rd_ok = {1'b0, raddr} < DEPTH_L;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dff_ram_lane #(
      .DEPTH       (DEPTH),
      .AW          (AW),
      .lane_data_t (lane_slice_t)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_ok && wmask[g]),
      .waddr_i (waddr),
      .wdata_i (wdata[g*LANE_W +: LANE_W]),
      .raddr_i (raddr),
      .rdata_o (rd_word[g*LANE_W +: LANE_W]),
      .perr_o  (lane_perr[g])
    );
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    perr_d   = 1'b0;
    if (!re_n) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_word : '0;
      perr_d   = rd_ok && (|lane_perr);
    end
  end

  // NOTE: non-blocking assignments for all state so registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      perr_q   <= perr_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign perr   = perr_q;

endmodule

// File: tb/tb_dff_ram_1r1w.sv
// Randomised self-checking bench for dff_ram_1r1w against an array-based model.
module tb_dff_ram_1r1w;

  localparam int W     = 72;
  localparam int D     = 5;
  localparam int LW    = 8;
  localparam int L     = W / LW;
  localparam int AW    = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we_n = 1'b1;
  logic [AW-1:0] waddr = '0;
  logic [W-1:0]  wdata = '0;
  logic [L-1:0]  wmask = '0;
  logic          re_n = 1'b1;
  logic [AW-1:0] raddr = '0;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          perr;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model [D];
  logic [W-1:0] exp_rdata  = '0;
  logic         exp_rvalid = 1'b0;
  logic         exp_perr_flag = 1'b0;

  dff_ram_1r1w #(.WIDTH(W), .DEPTH(D), .LANE_W(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .we_n   (we_n),
    .waddr  (waddr),
    .wdata  (wdata),
    .wmask  (wmask),
    .re_n   (re_n),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid),
    .perr   (perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_read(input int ra, input bit w, input int wa,
                                               input logic [W-1:0] wd, input logic [L-1:0] wm);
    logic [W-1:0] v;
    if (ra >= D) return '0;
    v = model[ra];
    if (w && wa == ra)
      for (int i = 0; i < L; i++)
        if (wm[i]) v[i*LW +: LW] = wd[i*LW +: LW];
    return v;
  endfunction

  task automatic step(input bit r, input bit w, input int wa, input logic [W-1:0] wd,
                      input logic [L-1:0] wm, input bit rd, input int ra);
    @(negedge clk);
    rst   = r;
    we_n  = !w;
    waddr = w ? AW'(wa) : 'x;
    wdata = wd;
    wmask = wm;
    re_n  = !rd;
    raddr = rd ? AW'(ra) : 'x;
    if (r) begin
      for (int i = 0; i < D; i++) model[i] = '0;
      exp_rdata  = '0;
      exp_rvalid = 1'b0;
    end else begin
      exp_rvalid = rd;
      if (rd) exp_rdata = model_read(ra, w, wa, wd, wm);
      if (w && wa < D)
        for (int i = 0; i < L; i++)
          if (wm[i]) model[wa][i*LW +: LW] = wd[i*LW +: LW];
    end
    @(posedge clk);
    #1;
    check("rvalid", W'(rvalid), W'(exp_rvalid));
    check("rdata", rdata, exp_rdata);
    check("perr", W'(perr), W'(exp_rvalid && exp_perr_flag));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] a5;
    ones = {W{1'b1}};
    a5   = {L{8'hA5}};
    for (int i = 0; i < D; i++) model[i] = '0;

    // reset, then first access one edge after deassertion
    step(1'b1, 1'b1, 2, ones, '1, 1'b1, 2);
    step(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    idle();

    // full write then read next cycle; rvalid for exactly one cycle
    step(1'b0, 1'b1, 2, 72'hFF_0123456789ABCDEF, 9'h1FF, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 2);
    check("seq_const", rdata, 72'hFF_0123456789ABCDEF);
    idle();

    // masked write of lane 0 only
    step(1'b0, 1'b1, 1, ones, 9'h1FF, 1'b0, 0);
    step(1'b0, 1'b1, 1, '0, 9'h001, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 1);
    check("mask_const", rdata, 72'hFF_FFFFFFFFFFFFFF00);

    // same-address write-first forwarding
    step(1'b0, 1'b1, 0, '0, 9'h1FF, 1'b0, 0);
    step(1'b0, 1'b1, 0, a5, 9'h0F0, 1'b1, 0);
    check("fwd_const", rdata, 72'h00_A5A5A5A5_00000000);

    // zero-mask write is a no-op
    step(1'b0, 1'b1, 2, ones, 9'h000, 1'b1, 2);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 2);

    // hold while idle, then out-of-range write dropped and read returns 0
    step(1'b0, 1'b1, 3, 72'h12_3456789A_BCDEF012, 9'h1FF, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 3);
    for (int i = 0; i < 3; i++) idle();
    step(1'b0, 1'b1, 6, ones, 9'h1FF, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 6);
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 0, '0, '0, 1'b1, i);

    // reset mid-stream suppresses the concurrent read and clears storage
    step(1'b0, 1'b1, 3, 72'h1, 9'h1FF, 1'b0, 0);
    step(1'b1, 1'b0, 0, '0, '0, 1'b1, 3);
    idle();
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 3);

`ifdef DFF_RAM_PARITY_EN
    // corrupt stored bit 0 of addr 1 behind the parity bit's back
    step(1'b0, 1'b1, 1, 72'h3, 9'h1FF, 1'b0, 0);
    dut.g_lane[0].u_lane.mem_q[1] = 8'h02;
    model[1][7:0] = 8'h02;
    exp_perr_flag = 1'b1;
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 1);
    exp_perr_flag = 1'b0;
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 0);
    step(1'b0, 1'b1, 1, 72'h3, 9'h1FF, 1'b0, 0);
`endif

    // random traffic, including out-of-range addresses and sporadic resets
    for (int n = 0; n < 600; n++) begin
      bit           r, w, rd;
      int           wa, ra;
      logic [W-1:0] wd;
      logic [L-1:0] wm;
      r  = ($urandom_range(0, 49) == 0);
      w  = $urandom_range(0, 2) != 0;
      rd = $urandom_range(0, 2) != 0;
      wa = $urandom_range(0, 7);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      wd = {$urandom(), $urandom(), 8'($urandom())};
      wm = 9'($urandom());
      step(r, w, wa, wd, wm, rd, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
